// File: rtl/bp_sacc_io_initiator.sv
// bp_sacc_io_initiator: single-outstanding uncached load/store initiator on the BedRock mem IO link,
// with io_resp timeout and a saturating count of unsolicited responses.
module bp_sacc_io_initiator #(
   parameter int paddr_width_p        = 40,
   parameter int lce_id_width_p       = 4,
   parameter int acache_fill_width_p  = 128,
   parameter int timeout_p            = 1024,
   localparam int mem_header_width_lp = lce_id_width_p + 3 + paddr_width_p + 8
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [lce_id_width_p-1:0]      lce_id_i,
   input  logic                           req_v_i,
   output logic                           req_ready_and_o,
   input  logic                           req_w_i,
   input  logic [paddr_width_p-1:0]       req_addr_i,
   input  logic [1:0]                     req_size_i,
   input  logic [63:0]                    req_data_i,
   output logic                           resp_v_o,
   input  logic                           resp_ready_and_i,
   output logic [63:0]                    resp_data_o,
   output logic                           resp_err_o,
   output logic [7:0]                     stray_cnt_o,
   output logic [mem_header_width_lp-1:0] io_cmd_header_o,
   output logic                           io_cmd_header_v_o,
   input  logic                           io_cmd_header_ready_and_i,
   output logic                           io_cmd_has_data_o,
   output logic [acache_fill_width_p-1:0] io_cmd_data_o,
   output logic                           io_cmd_data_v_o,
   input  logic                           io_cmd_data_ready_and_i,
   output logic                           io_cmd_last_o,
   input  logic [mem_header_width_lp-1:0] io_resp_header_i,
   input  logic                           io_resp_header_v_i,
   output logic                           io_resp_header_ready_and_o,
   input  logic [acache_fill_width_p-1:0] io_resp_data_i,
   input  logic                           io_resp_data_v_i,
   output logic                           io_resp_data_ready_and_o,
   input  logic                           io_resp_last_i
);
   typedef enum logic [2:0] {READY, SEND_HDR, SEND_DATA, WAIT_HDR, WAIT_DATA, DONE} state_e;
   localparam int tw_lp = $clog2(timeout_p) + 1;

   state_e                         state_q, state_d;
   logic [mem_header_width_lp-1:0] hdr_q, hdr_d;
   logic [63:0]                    data_q, data_d, resp_data_q, resp_data_d;
   logic                           w_q, w_d, err_q, err_d;
   logic [tw_lp-1:0]               timer_q, timer_d;
   logic [7:0]                     stray_q, stray_d;
   logic                           expired, hdr_acc, data_acc, stray;
   logic                           unused;

   assign unused = ^{io_resp_header_i, io_resp_last_i, io_resp_data_i[acache_fill_width_p-1:64]};

   assign req_ready_and_o            = state_q == READY;
   assign io_cmd_header_v_o          = state_q == SEND_HDR;
   assign io_cmd_data_v_o            = state_q == SEND_DATA;
   assign io_cmd_last_o              = io_cmd_data_v_o;
   assign io_cmd_header_o            = hdr_q;
   assign io_cmd_has_data_o          = w_q;
   assign io_cmd_data_o              = acache_fill_width_p'(data_q);
   assign resp_v_o                   = state_q == DONE;
   assign resp_data_o                = resp_data_q;
   assign resp_err_o                 = err_q;
   assign stray_cnt_o                = stray_q;
   // Idle states keep both response channels open so stray traffic drains instead of wedging the link
   assign io_resp_header_ready_and_o = state_q inside {READY, WAIT_HDR, DONE};
   assign io_resp_data_ready_and_o   = state_q inside {READY, WAIT_DATA, DONE};
   assign hdr_acc                    = io_resp_header_v_i & io_resp_header_ready_and_o;
   assign data_acc                   = io_resp_data_v_i & io_resp_data_ready_and_o;
   assign stray                      = hdr_acc & (state_q inside {READY, DONE});
   assign expired                    = timer_q >= tw_lp'(timeout_p - 1);

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      data_d      = data_q;
      w_d         = w_q;
      err_d       = err_q;
      resp_data_d = resp_data_q;
      timer_d     = (state_q inside {WAIT_HDR, WAIT_DATA}) && !expired ? timer_q + 1'b1 : timer_q;
      stray_d     = stray && stray_q != 8'hff ? stray_q + 1'b1 : stray_q;
      case (state_q)
         READY: if (req_v_i) begin
            state_d = SEND_HDR;
            // msg_type: uc_rd = 4'd2, uc_wr = 4'd3; subop 0
            hdr_d   = {lce_id_i, 1'b0, req_size_i, req_addr_i, 4'd0, 3'b001, req_w_i};
            data_d  = req_data_i;
            w_d     = req_w_i;
            timer_d = '0;
         end
         SEND_HDR:  if (io_cmd_header_ready_and_i) state_d = w_q ? SEND_DATA : WAIT_HDR;
         SEND_DATA: if (io_cmd_data_ready_and_i) state_d = WAIT_HDR;
         WAIT_HDR: if (hdr_acc) begin
            state_d     = w_q ? DONE : WAIT_DATA;
            err_d       = 1'b0;
            resp_data_d = '0;
         end else if (expired) begin
            state_d     = DONE;
            err_d       = 1'b1;
            resp_data_d = '0;
         end
         WAIT_DATA: if (data_acc) begin
            state_d     = DONE;
            err_d       = 1'b0;
            resp_data_d = io_resp_data_i[63:0];
         end else if (expired) begin
            state_d     = DONE;
            err_d       = 1'b1;
            resp_data_d = '0;
         end
         DONE:    if (resp_ready_and_i) state_d = READY;
         default: state_d = READY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= READY;
         hdr_q       <= '0;
         data_q      <= '0;
         w_q         <= 1'b0;
         err_q       <= 1'b0;
         resp_data_q <= '0;
         timer_q     <= '0;
         stray_q     <= '0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         data_q      <= data_d;
         w_q         <= w_d;
         err_q       <= err_d;
         resp_data_q <= resp_data_d;
         timer_q     <= timer_d;
         stray_q     <= stray_d;
      end
   end
endmodule

// File: tb/tb_bp_sacc_io_initiator.sv
// tb_bp_sacc_io_initiator: randomized transaction-level bench for the IO initiator,
// with expected headers/responses computed from the message rules by a small model.
module tb_bp_sacc_io_initiator;
   localparam int PA = 40, LW = 4, FW = 128, TO = 16, HW = LW + 3 + PA + 8;

   logic clk = 0, reset_n = 0;
   logic [LW-1:0] lce_id = '0;
   logic req_v = 0, req_ready, req_w = 0;
   logic [PA-1:0] req_addr = '0;
   logic [1:0] req_size = '0;
   logic [63:0] req_data = '0;
   logic resp_v, resp_ready = 1, resp_err;
   logic [63:0] resp_data;
   logic [7:0] stray_cnt;
   logic [HW-1:0] cmd_hdr;
   logic cmd_hdr_v, cmd_hdr_ready = 1, cmd_has_data;
   logic [FW-1:0] cmd_data;
   logic cmd_data_v, cmd_data_ready = 1, cmd_last;
   logic [HW-1:0] rsp_hdr = '0;
   logic rsp_hdr_v = 0, rsp_hdr_ready;
   logic [FW-1:0] rsp_data = '0;
   logic rsp_data_v = 0, rsp_data_ready, rsp_last = 1;

   int total = 0, bad = 0, beats = 0, exp_beats = 0, stray_exp = 0;

   bp_sacc_io_initiator #(.paddr_width_p(PA), .lce_id_width_p(LW), .acache_fill_width_p(FW), .timeout_p(TO)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
      .req_v_i(req_v), .req_ready_and_o(req_ready), .req_w_i(req_w), .req_addr_i(req_addr),
      .req_size_i(req_size), .req_data_i(req_data),
      .resp_v_o(resp_v), .resp_ready_and_i(resp_ready), .resp_data_o(resp_data), .resp_err_o(resp_err),
      .stray_cnt_o(stray_cnt),
      .io_cmd_header_o(cmd_hdr), .io_cmd_header_v_o(cmd_hdr_v), .io_cmd_header_ready_and_i(cmd_hdr_ready),
      .io_cmd_has_data_o(cmd_has_data), .io_cmd_data_o(cmd_data), .io_cmd_data_v_o(cmd_data_v),
      .io_cmd_data_ready_and_i(cmd_data_ready), .io_cmd_last_o(cmd_last),
      .io_resp_header_i(rsp_hdr), .io_resp_header_v_i(rsp_hdr_v), .io_resp_header_ready_and_o(rsp_hdr_ready),
      .io_resp_data_i(rsp_data), .io_resp_data_v_i(rsp_data_v), .io_resp_data_ready_and_o(rsp_data_ready),
      .io_resp_last_i(rsp_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (cmd_data_v && cmd_data_ready) beats <= beats + 1;

   // Header bit map: msg_type[3:0], subop[7:4], addr[8+:PA], size[8+PA+:3], lce_id above
   function automatic logic [HW-1:0] exp_hdr(input bit w, input logic [PA-1:0] a, input logic [1:0] sz, input logic [LW-1:0] id);
      logic [HW-1:0] h;
      h = HW'(w ? 3 : 2);
      h = h + (HW'(a) << 8) + (HW'(sz) << (8 + PA)) + (HW'(id) << (11 + PA));
      return h;
   endfunction

   task automatic do_req(input bit w, input logic [PA-1:0] a, input logic [1:0] sz, input logic [63:0] d, input logic [LW-1:0] id);
      int n = 0;
      req_v = 1; req_w = w; req_addr = a; req_size = sz; req_data = d; lce_id = id;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL req_accept timed out"); end
      @(negedge clk);
      req_v = 0;
   endtask

   task automatic get_hdr(output logic [HW-1:0] h, output logic hd, input int stall);
      int n = 0;
      cmd_hdr_ready = 0;
      repeat (stall) @(negedge clk);
      cmd_hdr_ready = 1;
      while (!cmd_hdr_v && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL cmd_header timed out"); end
      h = cmd_hdr; hd = cmd_has_data;
      @(negedge clk);
   endtask

   task automatic get_data(output logic [FW-1:0] d, output logic l, input int stall);
      int n = 0;
      cmd_data_ready = 0;
      repeat (stall) @(negedge clk);
      cmd_data_ready = 1;
      while (!cmd_data_v && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL cmd_data timed out"); end
      d = cmd_data; l = cmd_last;
      @(negedge clk);
   endtask

   task automatic put_resp_hdr();
      int n = 0;
      rsp_hdr_v = 1; rsp_hdr = HW'({$urandom, $urandom});
      while (!rsp_hdr_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL resp_header accept timed out"); end
      @(negedge clk);
      rsp_hdr_v = 0;
   endtask

   task automatic put_resp_data(input logic [63:0] d);
      int n = 0;
      rsp_data_v = 1; rsp_data = {$urandom, $urandom, d};
      while (!rsp_data_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL resp_data accept timed out"); end
      @(negedge clk);
      rsp_data_v = 0;
   endtask

   task automatic get_resp(output logic [63:0] d, output logic e);
      int n = 0;
      while (!resp_v && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin total++; bad++; $display("FAIL resp_v timed out"); end
      d = resp_data; e = resp_err;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 0;
      repeat (3) @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
      total++; if (cmd_hdr_v !== 1'b0) begin bad++; $display("FAIL reset_hdr_v got=%0b want=0", cmd_hdr_v); end
      total++; if (cmd_data_v !== 1'b0) begin bad++; $display("FAIL reset_data_v got=%0b want=0", cmd_data_v); end
      total++; if (resp_v !== 1'b0) begin bad++; $display("FAIL reset_resp_v got=%0b want=0", resp_v); end
      total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", resp_err); end
      total++; if (resp_data !== 64'h0) begin bad++; $display("FAIL reset_resp_data got=%0h want=0", resp_data); end
      total++; if (stray_cnt !== 8'h0) begin bad++; $display("FAIL reset_stray got=%0d want=0", stray_cnt); end
      reset_n = 1;
      @(negedge clk);
   endtask

   task automatic test_store();
      logic [PA-1:0] a; logic [63:0] d, rd; logic [1:0] sz; logic [LW-1:0] id;
      logic [HW-1:0] h; logic hd, l, e; logic [FW-1:0] cd;
      for (int i = 0; i < 6; i++) begin
         a = i == 0 ? PA'(40'h0020_0008) : PA'({$urandom, $urandom});
         d = i == 0 ? 64'hDEAD_BEEF : {$urandom, $urandom};
         sz = i == 0 ? 2'd3 : 2'($urandom_range(0, 3));
         id = LW'($urandom);
         do_req(1, a, sz, d, id);
         get_hdr(h, hd, $urandom_range(0, 2));
         total++; if (h !== exp_hdr(1, a, sz, id)) begin bad++; $display("FAIL store_hdr got=%0h want=%0h", h, exp_hdr(1, a, sz, id)); end
         total++; if (hd !== 1'b1) begin bad++; $display("FAIL store_has_data got=%0b want=1", hd); end
         get_data(cd, l, $urandom_range(0, 2));
         exp_beats++;
         total++; if (cd !== FW'(d)) begin bad++; $display("FAIL store_data got=%0h want=%0h", cd, FW'(d)); end
         total++; if (l !== 1'b1) begin bad++; $display("FAIL store_last got=%0b want=1", l); end
         repeat ($urandom_range(0, 5)) @(negedge clk);
         put_resp_hdr();
         get_resp(rd, e);
         total++; if (rd !== 64'h0 || e !== 1'b0) begin bad++; $display("FAIL store_resp got data=%0h err=%0b want data=0 err=0", rd, e); end
         total++; if (beats !== exp_beats) begin bad++; $display("FAIL store_beats got=%0d want=%0d", beats, exp_beats); end
      end
   endtask

   task automatic test_load();
      logic [PA-1:0] a; logic [63:0] d, rd; logic [1:0] sz; logic [LW-1:0] id;
      logic [HW-1:0] h; logic hd, e;
      for (int i = 0; i < 6; i++) begin
         a = i == 0 ? PA'(40'h0020_0008) : PA'({$urandom, $urandom});
         d = i == 0 ? 64'h1234_5678 : {$urandom, $urandom};
         sz = i == 0 ? 2'd3 : 2'($urandom_range(0, 3));
         id = LW'($urandom);
         do_req(0, a, sz, 64'h0, id);
         total++; if (cmd_hdr_v !== 1'b1) begin bad++; $display("FAIL load_hdr_latency got=%0b want=1", cmd_hdr_v); end
         get_hdr(h, hd, $urandom_range(0, 2));
         total++; if (h !== exp_hdr(0, a, sz, id)) begin bad++; $display("FAIL load_hdr got=%0h want=%0h", h, exp_hdr(0, a, sz, id)); end
         total++; if (hd !== 1'b0) begin bad++; $display("FAIL load_has_data got=%0b want=0", hd); end
         repeat ($urandom_range(0, 4)) @(negedge clk);
         put_resp_hdr();
         repeat ($urandom_range(0, 4)) @(negedge clk);
         put_resp_data(d);
         total++; if (resp_v !== 1'b1) begin bad++; $display("FAIL load_resp_latency got=%0b want=1", resp_v); end
         get_resp(rd, e);
         total++; if (rd !== d || e !== 1'b0) begin bad++; $display("FAIL load_resp got data=%0h err=%0b want data=%0h err=0", rd, e, d); end
         total++; if (beats !== exp_beats) begin bad++; $display("FAIL load_no_beat got=%0d want=%0d", beats, exp_beats); end
      end
   endtask

   task automatic test_stall();
      logic [HW-1:0] h; logic hd, e; logic [63:0] rd;
      do_req(0, PA'(40'h0000_1230), 2'd2, 64'h0, 4'h5);
      cmd_hdr_ready = 0;
      for (int k = 0; k < 20; k++) begin
         total++; if (cmd_hdr_v !== 1'b1 || cmd_hdr !== exp_hdr(0, PA'(40'h0000_1230), 2'd2, 4'h5) || resp_v !== 1'b0)
            begin bad++; $display("FAIL stall_hold cyc=%0d got v=%0b hdr=%0h resp_v=%0b", k, cmd_hdr_v, cmd_hdr, resp_v); end
         @(negedge clk);
      end
      get_hdr(h, hd, 0);
      put_resp_hdr();
      put_resp_data(64'hCAFE_F00D_0000_0001);
      get_resp(rd, e);
      total++; if (rd !== 64'hCAFE_F00D_0000_0001 || e !== 1'b0) begin bad++; $display("FAIL stall_resp got data=%0h err=%0b", rd, e); end
   endtask

   task automatic test_timeout();
      logic [HW-1:0] h; logic hd, e; logic [63:0] rd; logic [FW-1:0] cd;
      do_req(0, PA'(40'h0020_0008), 2'd3, 64'h0, 4'h1);
      get_hdr(h, hd, 0);
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         total++; if (resp_v !== (k == TO)) begin bad++; $display("FAIL timeout_cycle k=%0d got resp_v=%0b want=%0b", k, resp_v, k == TO); end
      end
      get_resp(rd, e);
      total++; if (rd !== 64'h0 || e !== 1'b1) begin bad++; $display("FAIL timeout_resp got data=%0h err=%0b want data=0 err=1", rd, e); end
      put_resp_hdr();
      put_resp_data(64'h1234_5678);
      stray_exp++;
      total++; if (stray_cnt !== 8'(stray_exp)) begin bad++; $display("FAIL late_stray got=%0d want=%0d", stray_cnt, stray_exp); end
      total++; if (resp_v !== 1'b0) begin bad++; $display("FAIL late_no_resp got=%0b want=0", resp_v); end
      do_req(1, PA'(40'h40), 2'd0, 64'h5A, 4'h2);
      get_hdr(h, hd, 0);
      get_data(cd, hd, 0);
      exp_beats++;
      repeat (TO - 1) @(negedge clk);
      put_resp_hdr();
      get_resp(rd, e);
      total++; if (e !== 1'b0) begin bad++; $display("FAIL timeout_tie got err=%0b want=0", e); end
   endtask

   task automatic test_stray_saturate();
      for (int i = 0; i < 260; i++) begin
         put_resp_hdr();
         if ($urandom_range(0, 3) == 0) put_resp_data(64'($urandom));
         stray_exp = stray_exp < 255 ? stray_exp + 1 : 255;
         total++; if (stray_cnt !== 8'(stray_exp)) begin bad++; $display("FAIL stray_cnt i=%0d got=%0d want=%0d", i, stray_cnt, stray_exp); end
      end
   endtask

   task automatic test_back_to_back();
      logic [HW-1:0] h; logic hd, l, e; logic [FW-1:0] cd; logic [63:0] rd;
      do_req(1, PA'(40'h100), 2'd3, 64'h1111, 4'h3);
      get_hdr(h, hd, 0);
      get_data(cd, l, 0);
      exp_beats++;
      resp_ready = 0;
      put_resp_hdr();
      req_v = 1; req_w = 0; req_addr = PA'(40'h208); req_size = 2'd1; lce_id = 4'h9;
      for (int k = 0; k < 5; k++) begin
         total++; if (resp_v !== 1'b1 || req_ready !== 1'b0 || cmd_hdr_v !== 1'b0)
            begin bad++; $display("FAIL b2b_hold k=%0d got resp_v=%0b req_ready=%0b hdr_v=%0b", k, resp_v, req_ready, cmd_hdr_v); end
         @(negedge clk);
      end
      resp_ready = 1;
      total++; if (resp_data !== 64'h0 || resp_err !== 1'b0) begin bad++; $display("FAIL b2b_store_resp got data=%0h err=%0b", resp_data, resp_err); end
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || cmd_hdr_v !== 1'b0 || resp_v !== 1'b0)
         begin bad++; $display("FAIL b2b_ready got req_ready=%0b hdr_v=%0b resp_v=%0b", req_ready, cmd_hdr_v, resp_v); end
      @(negedge clk);
      req_v = 0;
      total++; if (cmd_hdr_v !== 1'b1 || cmd_hdr !== exp_hdr(0, PA'(40'h208), 2'd1, 4'h9))
         begin bad++; $display("FAIL b2b_second_hdr got v=%0b hdr=%0h want=%0h", cmd_hdr_v, cmd_hdr, exp_hdr(0, PA'(40'h208), 2'd1, 4'h9)); end
      get_hdr(h, hd, 0);
      put_resp_hdr();
      put_resp_data(64'h00AB_CDEF);
      get_resp(rd, e);
      total++; if (rd !== 64'h00AB_CDEF || e !== 1'b0) begin bad++; $display("FAIL b2b_load_resp got data=%0h err=%0b", rd, e); end
   endtask

   task automatic test_reset_mid();
      logic [HW-1:0] h; logic hd;
      do_req(1, PA'(40'h300), 2'd3, 64'h7777, 4'h4);
      get_hdr(h, hd, 0);
      cmd_data_ready = 0;
      total++; if (cmd_data_v !== 1'b1) begin bad++; $display("FAIL mid_in_send_data got=%0b want=1", cmd_data_v); end
      #2 reset_n = 0;
      #1;
      total++; if (cmd_data_v !== 1'b0 || cmd_hdr_v !== 1'b0 || resp_v !== 1'b0 || req_ready !== 1'b1)
         begin bad++; $display("FAIL mid_async got data_v=%0b hdr_v=%0b resp_v=%0b req_ready=%0b", cmd_data_v, cmd_hdr_v, resp_v, req_ready); end
      @(negedge clk);
      reset_n = 1;
      stray_exp = 0;
      cmd_data_ready = 1;
      repeat (5) @(negedge clk);
      total++; if (beats !== exp_beats || cmd_hdr_v !== 1'b0 || req_ready !== 1'b1)
         begin bad++; $display("FAIL mid_no_reissue got beats=%0d want=%0d hdr_v=%0b req_ready=%0b", beats, exp_beats, cmd_hdr_v, req_ready); end
      total++; if (stray_cnt !== 8'(stray_exp)) begin bad++; $display("FAIL mid_stray_clear got=%0d want=0", stray_cnt); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_stall();
      test_timeout();
      test_stray_saturate();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
